// File: rtl/iir_ctrl_pkg.sv
// rtl/iir_ctrl_pkg.sv - shared types and constants for the IIR filter control path
package iir_ctrl_pkg;

   localparam int COEF_W    = 32;
   localparam int COEF_FRAC = 16;

   localparam logic [1:0] SEL_C1 = 2'b00;
   localparam logic [1:0] SEL_C2 = 2'b01;
   localparam logic [1:0] SEL_C3 = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD0 = 3'd1,
      LOAD1 = 3'd2,
      LOAD2 = 3'd3,
      FLUSH = 3'd4,
      RUN   = 3'd5
   } iir_seq_state_t;

endpackage

// File: rtl/iir_coef_sequencer.sv
// rtl/iir_coef_sequencer.sv - loads a coefficient set into the IIR stage, flushes its history, gates its enable
module iir_coef_sequencer
   import iir_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [COEF_W-1:0] cfg_c1,
   input  logic [COEF_W-1:0] cfg_c2,
   input  logic [COEF_W-1:0] cfg_c3,
   output logic [COEF_W-1:0] coefficient,
   output logic [1:0]        reg_select,
   output logic              enable_reg_select,
   output logic              n_1_reset,
   output logic              en,
   output logic              loaded,
   output logic              busy
);

   localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

   iir_seq_state_t    state, state_nxt;
   logic [7:0]        flush_cnt, flush_cnt_nxt;
   logic [COEF_W-1:0] hold_c2, hold_c3;
   logic              accept;

   logic              loaded_nxt;
   logic              cfg_ready_nxt;
   logic              busy_nxt;
   logic              en_nxt;
   logic              n_1_reset_nxt;
   logic              strobe_nxt;
   logic [1:0]        sel_nxt;
   logic [COEF_W-1:0] coef_nxt;

   assign accept = cfg_valid && cfg_ready;

   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      loaded_nxt    = loaded;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = LOAD0;
            end else if (run && loaded) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = FLUSH_LAST;
            end
         end
         RUN: begin
            // a new set takes priority over a simultaneous stop request
            if (accept) begin
               state_nxt = LOAD0;
            end else if (!run) begin
               state_nxt = IDLE;
            end
         end
         LOAD0: state_nxt = LOAD1;
         LOAD1: state_nxt = LOAD2;
         LOAD2: begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LAST;
         end
         FLUSH: begin
            if (flush_cnt == 8'd0) begin
               loaded_nxt = 1'b1;
               state_nxt  = run ? RUN : IDLE;
            end else begin
               flush_cnt_nxt = flush_cnt - 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered in step with it
   always_comb begin
      cfg_ready_nxt = 1'b0;
      busy_nxt      = 1'b0;
      en_nxt        = 1'b0;
      n_1_reset_nxt = 1'b0;
      strobe_nxt    = 1'b0;
      sel_nxt       = SEL_C1;
      coef_nxt      = '0;
      case (state_nxt)
         IDLE: cfg_ready_nxt = 1'b1;
         RUN: begin
            cfg_ready_nxt = 1'b1;
            en_nxt        = 1'b1;
         end
         LOAD0: begin
            busy_nxt   = 1'b1;
            strobe_nxt = 1'b1;
            sel_nxt    = SEL_C1;
            coef_nxt   = cfg_c1;
         end
         LOAD1: begin
            busy_nxt   = 1'b1;
            strobe_nxt = 1'b1;
            sel_nxt    = SEL_C2;
            coef_nxt   = hold_c2;
         end
         LOAD2: begin
            busy_nxt   = 1'b1;
            strobe_nxt = 1'b1;
            sel_nxt    = SEL_C3;
            coef_nxt   = hold_c3;
         end
         FLUSH: begin
            busy_nxt      = 1'b1;
            n_1_reset_nxt = 1'b1;
         end
         default: cfg_ready_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         flush_cnt         <= '0;
         hold_c2           <= '0;
         hold_c3           <= '0;
         cfg_ready         <= 1'b1;
         coefficient       <= '0;
         reg_select        <= SEL_C1;
         enable_reg_select <= 1'b0;
         n_1_reset         <= 1'b0;
         en                <= 1'b0;
         loaded            <= 1'b0;
         busy              <= 1'b0;
      end else begin
         state             <= state_nxt;
         flush_cnt         <= flush_cnt_nxt;
         if (accept) begin
            hold_c2 <= cfg_c2;
            hold_c3 <= cfg_c3;
         end
         cfg_ready         <= cfg_ready_nxt;
         coefficient       <= coef_nxt;
         reg_select        <= sel_nxt;
         enable_reg_select <= strobe_nxt;
         n_1_reset         <= n_1_reset_nxt;
         en                <= en_nxt;
         loaded            <= loaded_nxt;
         busy              <= busy_nxt;
      end
   end

endmodule

// File: doc/iir_coef_sequencer.md
# iir_coef_sequencer

Control sequencer that sits directly upstream of the IIR filter stage and owns its control interface. It accepts a three-coefficient set over a valid/ready handshake and writes the coefficients into the filter one per cycle. It then clears the filter's one-sample history and gates the filter's run enable. The filter never sees a coefficient update while it is filtering, and never resumes filtering with stale x[n-1]/y[n-1] state.

## Interface
- FLUSH_CYCLES, 2, number of cycles `n_1_reset` is held high after a load or resume; legal range 1..255.

- clk  input  1  sole clock; all logic rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- run  input  1  level request: filter active when high.
- cfg_valid  input  1  coefficient set offered.
- cfg_ready  output  1  sequencer can accept a set.
- cfg_c1  input  32  signed coefficient for the x[n] term (Q16.16).
- cfg_c2  input  32  signed coefficient for the x[n-1] term (Q16.16).
- cfg_c3  input  32  signed coefficient for the y[n-1] term (Q16.16).
- coefficient  output  32  coefficient data to the filter.
- reg_select  output  2  filter coefficient slot: 00=c1, 01=c2, 10=c3; 11 is never driven.
- enable_reg_select  output  1  coefficient write strobe to the filter.
- n_1_reset  output  1  clears the filter history registers.
- en  output  1  filter run enable; when low the filter passes x through.
- loaded  output  1  a full coefficient set has been written since reset.
- busy  output  1  sequencer is in LOAD or FLUSH.

## Operation
- All outputs are registered. Reset value of every output is 0, except `cfg_ready`, which is 1 (the reset state is IDLE).
- States: IDLE, LOAD0, LOAD1, LOAD2, FLUSH, RUN.
- A handshake completes on a cycle where `cfg_valid && cfg_ready`. On that cycle c1/c2/c3 are latched into internal holding registers.
- `cfg_ready` is 1 in IDLE and RUN only.
- IDLE:
  - Accepted set -> LOAD0.
  - Otherwise, `run && loaded` -> FLUSH.
  - Otherwise stay in IDLE. While `loaded`=0, `run` is ignored.
- RUN:
  - Accepted set -> LOAD0. `en` drops in the same registered update.
  - Otherwise, `!run` -> IDLE.
  - A set arriving with `run` falling in the same cycle: the set wins.
- LOADk (k=0,1,2): `enable_reg_select`=1, `reg_select`=k, `coefficient`=held c(k+1). LOAD0 -> LOAD1 -> LOAD2 -> FLUSH unconditionally.
- FLUSH:
  - `n_1_reset`=1 for exactly FLUSH_CYCLES cycles (down-counter).
  - On exit, `loaded`<=1, then go to RUN if `run`, else IDLE.
  - `run` is sampled on the last FLUSH cycle only.
- Mutual exclusion is guaranteed: at most one of `enable_reg_select`, `n_1_reset`, `en` is high in any cycle.
- `coefficient` and `reg_select` return to 0 outside the LOAD states.
- Reset mid-sequence returns immediately to IDLE with `loaded`=0. The filter's own coefficient registers are not touched; a new set must be loaded before `run` is honoured.

## Timing
- Handshake at cycle T:
  - `enable_reg_select` high at T+1..T+3, with `reg_select` 0, 1, 2 in that order.
  - `n_1_reset` high at T+4..T+3+F, where F = FLUSH_CYCLES.
  - `en` high from T+4+F if `run` was high on the last FLUSH cycle.
- Resume from IDLE (`run` rises at cycle T with `loaded`=1): `n_1_reset` high at T+1..T+F, `en` high at T+F+1.
- Stop: `run` low at cycle T in RUN -> `en` low at T+1.
- `busy` is high exactly during the LOAD and FLUSH cycles.
- `cfg_ready` is low from T+1 until the cycle after FLUSH exits.

## Structure
- Shared package `iir_ctrl_pkg`:
  - state enum `iir_seq_state_t`.
  - reg_select codes `SEL_C1`=2'b00, `SEL_C2`=2'b01, `SEL_C3`=2'b10.
  - coefficient width constant `COEF_W`=32.
  - Q16.16 fractional-bit constant `COEF_FRAC`=16.
- Single module, no sub-modules. FSM, FLUSH down-counter (8-bit), and holding registers live together.

## Test plan
- Load from reset: c1=32'h0000_8000, c2=32'h0000_0000, c3=32'h0000_4000 with `run`=1, F=2 -> strobes at T+1..T+3 carrying those values on slots 0/1/2; `n_1_reset` at T+4, T+5; `en` at T+6; `loaded`=1.
- `run` asserted with `loaded`=0 -> no output activity for 20 cycles; `cfg_ready` stays 1.
- Reload while running: set c1=32'hFFFF_0000 offered in RUN -> `en` low at T+1; full LOAD/FLUSH sequence; `en` back high at T+6.
- `cfg_valid` and `run` falling in the same RUN cycle -> set accepted; sequence ends in IDLE with `en`=0 and `loaded`=1.
- `reset_n` pulsed low during LOAD1 -> all outputs 0 asynchronously, `cfg_ready`=1, `loaded`=0; a later `run` is ignored until a reload.
- Resume with F=5: IDLE, `loaded`=1, `run` rises -> exactly 5 `n_1_reset` cycles, `en` on the 6th. All runs check that the mutual-exclusion assertion never fires.
